// File: rtl/mipi_frame_meas_if.sv
// mipi_frame_meas_if: pixel stream in, frame measurement results out
interface mipi_frame_meas_if #(
   parameter int DATA_WIDTH = 10,
   parameter int CNT_WIDTH  = 16
);
   logic                  enable;
   logic [DATA_WIDTH-1:0] dat;
   logic                  dv;
   logic                  lv;
   logic                  fv;
   logic [CNT_WIDTH-1:0]  width;
   logic [CNT_WIDTH-1:0]  height;
   logic [7:0]            width_err;
   logic [31:0]           frame_sum;
   logic [15:0]           frame_count;
   logic                  frame_done;
   modport master (
      output enable, dat, dv, lv, fv,
      input  width, height, width_err, frame_sum, frame_count, frame_done
   );
   modport slave (
      input  enable, dat, dv, lv, fv,
      output width, height, width_err, frame_sum, frame_count, frame_done
   );
endinterface

// File: rtl/mipi_frame_meas.sv
// mipi_frame_meas: per-frame width/height/width-error/pixel-sum measurement,
// published as frame-stable registers with a one-cycle frame_done strobe
module mipi_frame_meas #(
   parameter int DATA_WIDTH = 10,
   parameter int CNT_WIDTH  = 16
) (
   input logic               img_clk,
   input logic               resetb,
   mipi_frame_meas_if.slave  bus
);
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_FRAME = 1'b1;

   logic [0:0]           state_q, state_d;
   logic                 fv_q, lv_q;
   logic [CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d, ref_width_q, ref_width_d;
   logic [7:0]           err_cnt_q, err_cnt_d;
   logic [31:0]          sum_q, sum_d;
   logic                 first_line_q, first_line_d;
   logic [CNT_WIDTH-1:0] width_q, width_d, height_q, height_d;
   logic [7:0]           width_err_q, width_err_d;
   logic [31:0]          frame_sum_q, frame_sum_d;
   logic [15:0]          frame_count_q, frame_count_d;
   logic                 done_q, done_d;
   logic                 pix_hit, line_close, frame_close;

   assign pix_hit     = bus.dv & bus.lv & bus.fv;
   // a line also closes when fv drops underneath a still-high lv
   assign line_close  = lv_q & (~bus.lv | (fv_q & ~bus.fv));
   assign frame_close = fv_q & ~bus.fv;

   always_comb begin
      state_d       = state_q;
      pix_cnt_d     = pix_cnt_q;
      line_cnt_d    = line_cnt_q;
      ref_width_d   = ref_width_q;
      err_cnt_d     = err_cnt_q;
      sum_d         = sum_q;
      first_line_d  = first_line_q;
      width_d       = width_q;
      height_d      = height_q;
      width_err_d   = width_err_q;
      frame_sum_d   = frame_sum_q;
      frame_count_d = frame_count_q;
      done_d        = 1'b0;
      if (!bus.enable) begin
         state_d = ST_IDLE;
      end else if (state_q == ST_IDLE) begin
         if (bus.fv && !fv_q) begin
            state_d      = ST_FRAME;
            pix_cnt_d    = '0;
            line_cnt_d   = '0;
            ref_width_d  = '0;
            err_cnt_d    = '0;
            sum_d        = '0;
            first_line_d = 1'b1;
         end
      end else begin
         if (pix_hit) begin
            pix_cnt_d = (&pix_cnt_q) ? pix_cnt_q : pix_cnt_q + 1'b1;
            sum_d     = sum_q + 32'(bus.dat[DATA_WIDTH-1:0]);
         end
         if (line_close) begin
            pix_cnt_d = '0;
            if (pix_cnt_q != '0) begin
               line_cnt_d = (&line_cnt_q) ? line_cnt_q : line_cnt_q + 1'b1;
               if (first_line_q) begin
                  ref_width_d  = pix_cnt_q;
                  first_line_d = 1'b0;
               end else if (pix_cnt_q != ref_width_q) begin
                  err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
               end
            end
         end
         // publish the line-close-updated values so the last line is included
         if (frame_close) begin
            width_d       = ref_width_d;
            height_d      = line_cnt_d;
            width_err_d   = err_cnt_d;
            frame_sum_d   = sum_d;
            frame_count_d = frame_count_q + 1'b1;
            done_d        = 1'b1;
            state_d       = ST_IDLE;
         end
      end
   end

   always_ff @(posedge img_clk or negedge resetb) begin
      if (!resetb) begin
         state_q       <= ST_IDLE;
         fv_q          <= 1'b0;
         lv_q          <= 1'b0;
         pix_cnt_q     <= '0;
         line_cnt_q    <= '0;
         ref_width_q   <= '0;
         err_cnt_q     <= '0;
         sum_q         <= '0;
         first_line_q  <= 1'b0;
         width_q       <= '0;
         height_q      <= '0;
         width_err_q   <= '0;
         frame_sum_q   <= '0;
         frame_count_q <= '0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         fv_q          <= bus.fv;
         lv_q          <= bus.lv;
         pix_cnt_q     <= pix_cnt_d;
         line_cnt_q    <= line_cnt_d;
         ref_width_q   <= ref_width_d;
         err_cnt_q     <= err_cnt_d;
         sum_q         <= sum_d;
         first_line_q  <= first_line_d;
         width_q       <= width_d;
         height_q      <= height_d;
         width_err_q   <= width_err_d;
         frame_sum_q   <= frame_sum_d;
         frame_count_q <= frame_count_d;
         done_q        <= done_d;
      end
   end

   assign bus.width       = width_q;
   assign bus.height      = height_q;
   assign bus.width_err   = width_err_q;
   assign bus.frame_sum   = frame_sum_q;
   assign bus.frame_count = frame_count_q;
   assign bus.frame_done  = done_q;
endmodule

// File: tb/tb_mipi_frame_meas.sv
// tb_mipi_frame_meas: directed frames with hand-computed measurements
module tb_mipi_frame_meas;
   logic img_clk = 1'b0;
   logic resetb  = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   done_cnt = 0;
   int   dval     = 1;
   int   d0;

   mipi_frame_meas_if #(.DATA_WIDTH(10), .CNT_WIDTH(16)) bus ();

   mipi_frame_meas #(.DATA_WIDTH(10), .CNT_WIDTH(16)) dut (
      .img_clk (img_clk),
      .resetb  (resetb),
      .bus     (bus.slave)
   );

   always #5 img_clk = ~img_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input logic dv, input logic lv, input logic fv, input logic [9:0] d);
      bus.dv  = dv;
      bus.lv  = lv;
      bus.fv  = fv;
      bus.dat = d;
      @(posedge img_clk);
      #1;
      if (bus.frame_done) done_cnt++;
   endtask

   task automatic run_line(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b1, 1'b1, 1'b1, 10'(dval));
         dval++;
      end
      step(1'b0, 1'b0, 1'b1, 10'd0);
   endtask

   task automatic fstart();
      dval = 1;
      step(1'b0, 1'b0, 1'b0, 10'd0);
      step(1'b0, 1'b0, 1'b1, 10'd0);
   endtask

   task automatic fend();
      step(1'b0, 1'b0, 1'b0, 10'd0);
   endtask

   task automatic check_frame(input string tag, input int w, input int h, input int e,
                              input int s, input int c);
      check({tag, "_done"},  32'(bus.frame_done), 32'd1);
      check({tag, "_width"}, 32'(bus.width), 32'(w));
      check({tag, "_height"}, 32'(bus.height), 32'(h));
      check({tag, "_werr"},  32'(bus.width_err), 32'(e));
      check({tag, "_sum"},   bus.frame_sum, 32'(s));
      check({tag, "_count"}, 32'(bus.frame_count), 32'(c));
      step(1'b0, 1'b0, 1'b0, 10'd0);
      check({tag, "_done_low"}, 32'(bus.frame_done), 32'd0);
      check({tag, "_hold_w"},   32'(bus.width), 32'(w));
   endtask

   initial begin
      bus.enable = 1'b1;
      bus.dv = 1'b0; bus.lv = 1'b0; bus.fv = 1'b0; bus.dat = '0;
      repeat (2) @(posedge img_clk);
      #1;
      check("rst_width", 32'(bus.width), 32'd0);
      check("rst_count", 32'(bus.frame_count), 32'd0);
      check("rst_done", 32'(bus.frame_done), 32'd0);
      resetb = 1'b1;

      fstart(); run_line(4); run_line(4); run_line(4); fend();
      check_frame("t1", 4, 3, 0, 78, 1);

      fstart(); run_line(8); run_line(8); run_line(7); run_line(9); fend();
      check_frame("t2", 8, 4, 2, 528, 2);

      fstart(); run_line(5); run_line(5);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1, 1'b1, 10'(dval));
         dval++;
      end
      d0 = done_cnt;
      step(1'b0, 1'b1, 1'b0, 10'd0);
      check("t3_done_cnt", 32'(done_cnt - d0), 32'd1);
      check_frame("t3", 5, 3, 0, 120, 3);

      d0 = done_cnt;
      fstart(); run_line(4);
      bus.enable = 1'b0;
      run_line(4);
      bus.enable = 1'b1;
      run_line(4); fend();
      step(1'b0, 1'b0, 1'b0, 10'd0);
      check("t4_no_done", 32'(done_cnt - d0), 32'd0);
      check("t4_count_hold", 32'(bus.frame_count), 32'd3);
      fstart(); run_line(6); run_line(6); fend();
      check("t4_one_done", 32'(done_cnt - d0), 32'd1);
      check_frame("t4", 6, 2, 0, 78, 4);

      fstart(); run_line(3);
      step(1'b1, 1'b0, 1'b1, 10'd7);
      step(1'b0, 1'b1, 1'b1, 10'd0);
      step(1'b0, 1'b0, 1'b1, 10'd0);
      step(1'b1, 1'b0, 1'b1, 10'd9);
      run_line(3); fend();
      check_frame("t5", 3, 2, 0, 21, 5);

      fstart();
      step(1'b1, 1'b1, 1'b1, 10'd5);
      step(1'b1, 1'b1, 1'b1, 10'd6);
      #2 resetb = 1'b0;
      #1;
      check("t6_rst_count", 32'(bus.frame_count), 32'd0);
      check("t6_rst_width", 32'(bus.width), 32'd0);
      check("t6_rst_sum", bus.frame_sum, 32'd0);
      bus.dv = 1'b0; bus.lv = 1'b0; bus.fv = 1'b0;
      #2 resetb = 1'b1;
      fstart(); run_line(4); run_line(4); run_line(4); fend();
      check_frame("t6", 4, 3, 0, 78, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
